// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: op-code constants, nibble width and the
// status-flag FSM state type.
package alsu_pkg;

   localparam int unsigned NIBBLE_W = 4;

   localparam logic [3:0] SEL_ADD = 4'b0000;
   localparam logic [3:0] SEL_INC = 4'b1110;

   typedef enum logic [1:0] {
      IDLE,
      CHAIN,
      DONE
   } state_t;

endpackage

// File: rtl/alsu_overflow_detect.sv
// Combinational signed-overflow detection for the ALSU ops that can overflow
// (add and increment); every other op reports no overflow.
module alsu_overflow_detect
   import alsu_pkg::*;
(
   input  logic [3:0] sel,
   input  logic       a_msb,
   input  logic       b_msb,
   input  logic       res_msb,
   output logic       v
);

   always_comb begin
      v = 1'b0;
      case (sel)
         SEL_ADD: v = (a_msb == b_msb) && (res_msb != a_msb);
         SEL_INC: v = !a_msb && res_msb;
         default: v = 1'b0;
      endcase
   end

endmodule

// File: rtl/alsu_status_flags.sv
// Registered C/Z/N/V status stage behind the ALSU, with sticky carry and
// chained multi-nibble support (carry feedback and Z accumulation).
module alsu_status_flags
   import alsu_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                        Clk,
   input  logic                        Rst_n,
   input  logic [3:0]                  Sel,
   input  logic [NIBBLE_W-1:0]         Result,
   input  logic                        Carry_Out,
   input  logic                        A_Msb,
   input  logic                        B_Msb,
   input  logic                        Result_Valid,
   input  logic                        Chain_En,
   input  logic                        Flags_Clear,
   output logic                        Ready,
   output logic                        C_Flag,
   output logic                        Z_Flag,
   output logic                        N_Flag,
   output logic                        V_Flag,
   output logic                        Sticky_C,
   output logic                        Carry_In_Next,
   output logic                        Flags_Valid,
   output logic                        Chain_Err,
   output logic [$clog2(NIBBLES)-1:0]  Chain_Count
);

   localparam int unsigned   CW        = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST_BEAT = CW'(NIBBLES - 1);

   state_t state;
   logic   z_acc;
   logic   res_zero;
   logic   v_beat;
   logic   accept;
   logic   single_op;
   logic   chain_start;
   logic   chain_beat;
   logic   final_beat;
   logic   abort;
   logic   flags_write;

   alsu_overflow_detect u_ovf (
      .sel     (Sel),
      .a_msb   (A_Msb),
      .b_msb   (B_Msb),
      .res_msb (Result[NIBBLE_W-1]),
      .v       (v_beat)
   );

   always_comb begin
      res_zero    = (Result == '0);
      accept      = Result_Valid && (state != DONE);
      single_op   = accept && (state == IDLE) && !Chain_En;
      chain_start = accept && (state == IDLE) && Chain_En;
      chain_beat  = accept && (state == CHAIN) && Chain_En;
      final_beat  = chain_beat && (Chain_Count == LAST_BEAT);
      abort       = accept && (state == CHAIN) && !Chain_En;
      flags_write = single_op || final_beat;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state         <= IDLE;
         z_acc         <= 1'b0;
         Ready         <= 1'b1;
         C_Flag        <= 1'b0;
         Z_Flag        <= 1'b0;
         N_Flag        <= 1'b0;
         V_Flag        <= 1'b0;
         Sticky_C      <= 1'b0;
         Carry_In_Next <= 1'b0;
         Flags_Valid   <= 1'b0;
         Chain_Err     <= 1'b0;
         Chain_Count   <= '0;
      end else begin
         Flags_Valid <= flags_write;
         Chain_Err   <= abort;
         Sticky_C    <= (Sticky_C && !Flags_Clear) || (flags_write && Carry_Out);

         // Z for a single op is just this result; for a final beat it folds in the chain accumulator
         if (flags_write) begin
            C_Flag <= Carry_Out;
            Z_Flag <= res_zero && (single_op || z_acc);
            N_Flag <= Result[NIBBLE_W-1];
            V_Flag <= v_beat;
         end

         case (state)
            IDLE: begin
               if (single_op) begin
                  state <= DONE;
                  Ready <= 1'b0;
               end else if (chain_start) begin
                  state         <= CHAIN;
                  z_acc         <= res_zero;
                  Carry_In_Next <= Carry_Out;
                  Chain_Count   <= CW'(1);
               end
            end
            CHAIN: begin
               if (final_beat) begin
                  state         <= DONE;
                  Ready         <= 1'b0;
                  Carry_In_Next <= 1'b0;
                  Chain_Count   <= '0;
               end else if (chain_beat) begin
                  z_acc         <= z_acc && res_zero;
                  Carry_In_Next <= Carry_Out;
                  Chain_Count   <= Chain_Count + CW'(1);
               end else if (abort) begin
                  state         <= IDLE;
                  Carry_In_Next <= 1'b0;
                  Chain_Count   <= '0;
               end
            end
            DONE: begin
               state <= IDLE;
               Ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
